// File: rtl/if_id_pipe.sv
// if_id_pipe: fetch/decode pipeline register with a one-entry skid buffer.
// Carries {pc, inst} pairs in order, one per cycle. A decode stall never
// drops a fetched pair, and ready_o depends only on registered state.
// Optional build macro: IF_ID_PERF_EN adds saturating stall/flush counters.
//
// Handshake: a pair moves across an interface on a rising edge when its
// valid and ready are both high in that cycle. The upstream side holds
// pc_i/inst_i stable while valid_i && !ready_o. The downstream side sees
// pc_o/inst_o stable while valid_o && !ready_i (flush and reset excepted).
module if_id_pipe #(
  parameter int unsigned PC_W = 32,
  parameter int unsigned INST_W = 32,
  parameter logic [INST_W-1:0] NOP_INST = '0,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [INST_W-1:0] inst_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic [PC_W-1:0]   pc_o,
  output logic [INST_W-1:0] inst_o,
  input  logic              ready_i
`ifdef IF_ID_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
`endif
);

  // Skid entry: holds the pair accepted while the output entry was stalled.
  // It is always older than anything still waiting at the input.
  logic              skid_v;
  logic [PC_W-1:0]   skid_pc;
  logic [INST_W-1:0] skid_inst;

  logic acc;
  logic con;

  // ready_o comes straight from a flop, so there is no path from ready_i.
  assign ready_o = !skid_v;
  assign acc     = valid_i && ready_o && !flush_i;
  assign con     = valid_o && ready_i;

  // Output and skid entries: flush, then refill/drain, then hold-and-absorb.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o   <= 1'b0;
      pc_o      <= '0;
      inst_o    <= NOP_INST;
      skid_v    <= 1'b0;
      skid_pc   <= '0;
      skid_inst <= '0;
    end else if (flush_i) begin
      // Squash both entries and the incoming pair; pc_o keeps its last value.
      valid_o <= 1'b0;
      inst_o  <= NOP_INST;
      skid_v  <= 1'b0;
    end else if (!valid_o || con) begin
      if (skid_v) begin
        // Drain the older skid pair first to keep program order.
        valid_o <= 1'b1;
        pc_o    <= skid_pc;
        inst_o  <= skid_inst;
        if (acc) begin
          skid_pc   <= pc_i;
          skid_inst <= inst_i;
        end else begin
          skid_v <= 1'b0;
        end
      end else if (acc) begin
        valid_o <= 1'b1;
        pc_o    <= pc_i;
        inst_o  <= inst_i;
      end else begin
        // Bubble: present a NOP and keep the last PC for debug visibility.
        valid_o <= 1'b0;
        inst_o  <= NOP_INST;
      end
    end else if (acc) begin
      // Output is stalled; absorb the one in-flight pair into the skid.
      skid_v    <= 1'b1;
      skid_pc   <= pc_i;
      skid_inst <= inst_i;
    end
  end

`ifdef IF_ID_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Saturating counters for stalled cycles and flushes that squash something.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (valid_o && !ready_i && (stall_cnt_o != CNT_MAX)) begin
        stall_cnt_o <= stall_cnt_o + 1'b1;
      end
      if (flush_i && (valid_o || skid_v || valid_i) && (flush_cnt_o != CNT_MAX)) begin
        flush_cnt_o <= flush_cnt_o + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_id_pipe.sv
// tb_if_id_pipe: directed bench for if_id_pipe. Covers reset, streaming,
// skid capture/drain, flush (stalled and unstalled), bubbles, asynchronous
// reset mid-operation and, when IF_ID_PERF_EN is defined, the counters.
module tb_if_id_pipe;

  localparam int unsigned PC_W = 32;
  localparam int unsigned INST_W = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int unsigned CNT_W = 4;

  logic              clk_i;
  logic              rst_i;
  logic              flush_i;
  logic              valid_i;
  logic [PC_W-1:0]   pc_i;
  logic [INST_W-1:0] inst_i;
  logic              ready_o;
  logic              valid_o;
  logic [PC_W-1:0]   pc_o;
  logic [INST_W-1:0] inst_o;
  logic              ready_i;
`ifdef IF_ID_PERF_EN
  logic [CNT_W-1:0]  stall_cnt_o;
  logic [CNT_W-1:0]  flush_cnt_o;
`endif

  int n_total = 0;
  int n_pass  = 0;

  if_id_pipe #(
    .PC_W(PC_W),
    .INST_W(INST_W),
    .NOP_INST(NOP),
    .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .flush_i(flush_i),
    .valid_i(valid_i),
    .pc_i(pc_i),
    .inst_i(inst_i),
    .ready_o(ready_o),
    .valid_o(valid_o),
    .pc_o(pc_o),
    .inst_o(inst_o),
    .ready_i(ready_i)
`ifdef IF_ID_PERF_EN
    ,
    .stall_cnt_o(stall_cnt_o),
    .flush_cnt_o(flush_cnt_o)
`endif
  );

  // Clock: 10 time-unit period.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Instruction word derived from the PC so each pair is distinguishable.
  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return 32'hA500_0000 | pc;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic [31:0] pc);
    valid_i = v;
    pc_i    = pc;
    inst_i  = inst_of(pc);
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] pc,
                         input logic [31:0] inst, input logic rdy);
    chk({tag, ".valid"}, {31'd0, valid_o}, {31'd0, v});
    chk({tag, ".pc"},    pc_o, pc);
    chk({tag, ".inst"},  inst_o, inst);
    chk({tag, ".ready"}, {31'd0, ready_o}, {31'd0, rdy});
  endtask

  initial begin
    // Reset phase
    rst_i = 1'b1;
    flush_i = 1'b0;
    ready_i = 1'b0;
    drive(1'b0, 32'h0);
    tick();
    tick();
    rst_i = 1'b0;
    tick();
    chk_out("reset", 1'b0, 32'h0, NOP, 1'b1);

    // Streaming: one pair per cycle, one-cycle latency, ready_o stays high
    ready_i = 1'b1;
    drive(1'b1, 32'h00); tick(); chk_out("stream0", 1'b1, 32'h00, inst_of(32'h00), 1'b1);
    drive(1'b1, 32'h04); tick(); chk_out("stream1", 1'b1, 32'h04, inst_of(32'h04), 1'b1);
    drive(1'b1, 32'h08); tick(); chk_out("stream2", 1'b1, 32'h08, inst_of(32'h08), 1'b1);
    drive(1'b0, 32'hdead_beef); tick(); chk_out("stream_end", 1'b0, 32'h08, NOP, 1'b1);

    // Skid: 0x10 in output, stall, offer 0x14 then 0x18
    drive(1'b1, 32'h10); tick(); chk_out("skid_load", 1'b1, 32'h10, inst_of(32'h10), 1'b1);
    ready_i = 1'b0;
    drive(1'b1, 32'h14); tick(); chk_out("skid_cap", 1'b1, 32'h10, inst_of(32'h10), 1'b0);
    drive(1'b1, 32'h18); tick(); chk_out("skid_hold", 1'b1, 32'h10, inst_of(32'h10), 1'b0);
    ready_i = 1'b1;      tick(); chk_out("skid_drain", 1'b1, 32'h14, inst_of(32'h14), 1'b1);
                         tick(); chk_out("skid_next", 1'b1, 32'h18, inst_of(32'h18), 1'b1);
    drive(1'b0, 32'h0);  tick(); chk_out("skid_empty", 1'b0, 32'h18, NOP, 1'b1);

    // Flush while stalled with both entries full; 0x28 must never appear
    drive(1'b1, 32'h20); tick(); chk_out("fl_load", 1'b1, 32'h20, inst_of(32'h20), 1'b1);
    ready_i = 1'b0;
    drive(1'b1, 32'h24); tick(); chk_out("fl_skid", 1'b1, 32'h20, inst_of(32'h20), 1'b0);
    flush_i = 1'b1;
    drive(1'b1, 32'h28); tick(); chk_out("fl_squash", 1'b0, 32'h20, NOP, 1'b1);
    flush_i = 1'b0;
    ready_i = 1'b1;
    drive(1'b0, 32'h0);  tick(); chk_out("fl_after", 1'b0, 32'h20, NOP, 1'b1);

    // Flush with ready_i and valid_i high: output squashed, input dropped
    drive(1'b1, 32'h2c); tick(); chk_out("fl2_load", 1'b1, 32'h2c, inst_of(32'h2c), 1'b1);
    flush_i = 1'b1;
    drive(1'b1, 32'h3c); tick(); chk_out("fl2_squash", 1'b0, 32'h2c, NOP, 1'b1);
    flush_i = 1'b0;
    drive(1'b0, 32'h0);  tick(); chk_out("fl2_after", 1'b0, 32'h2c, NOP, 1'b1);

    // Bubble: two idle cycles between 0x30 and 0x34
    drive(1'b1, 32'h30); tick(); chk_out("bub_load", 1'b1, 32'h30, inst_of(32'h30), 1'b1);
    drive(1'b0, 32'h99); tick(); chk_out("bub_gap0", 1'b0, 32'h30, NOP, 1'b1);
                         tick(); chk_out("bub_gap1", 1'b0, 32'h30, NOP, 1'b1);
    drive(1'b1, 32'h34); tick(); chk_out("bub_next", 1'b1, 32'h34, inst_of(32'h34), 1'b1);

    // Asynchronous reset mid-cycle with both entries full
    drive(1'b1, 32'h50); tick(); chk_out("rst_load", 1'b1, 32'h50, inst_of(32'h50), 1'b1);
    ready_i = 1'b0;
    drive(1'b1, 32'h54); tick(); chk_out("rst_full", 1'b1, 32'h50, inst_of(32'h50), 1'b0);
    drive(1'b0, 32'h0);
    #2;
    rst_i = 1'b1;
    #1;
    chk_out("rst_async", 1'b0, 32'h0, NOP, 1'b1);
    tick();
    rst_i = 1'b0;
    ready_i = 1'b1;
    tick();
    chk_out("rst_after", 1'b0, 32'h0, NOP, 1'b1);

`ifdef IF_ID_PERF_EN
    // Counters: reset value, stall saturation at 15, flush count of 3
    chk("perf_stall_rst", {28'd0, stall_cnt_o}, 32'd0);
    chk("perf_flush_rst", {28'd0, flush_cnt_o}, 32'd0);
    drive(1'b1, 32'h60); tick();
    ready_i = 1'b0;
    drive(1'b0, 32'h0);
    for (int i = 0; i < 5; i++) tick();
    chk("perf_stall_5", {28'd0, stall_cnt_o}, 32'd5);
    for (int i = 0; i < 15; i++) tick();
    chk("perf_stall_sat", {28'd0, stall_cnt_o}, 32'd15);
    chk("perf_stall_out", pc_o, 32'h60);
    for (int k = 0; k < 3; k++) begin
      ready_i = 1'b1;
      drive(1'b1, 32'h70 + 32'(k * 4)); tick();
      ready_i = 1'b0;
      drive(1'b0, 32'h0);
      flush_i = 1'b1; tick();
      flush_i = 1'b0;
    end
    chk("perf_flush_3", {28'd0, flush_cnt_o}, 32'd3);
    // A flush with nothing held or offered does not count
    flush_i = 1'b1; tick();
    flush_i = 1'b0; tick();
    chk("perf_flush_idle", {28'd0, flush_cnt_o}, 32'd3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/if_id_pipe.md
# if_id_pipe

Parametrised fetch/decode pipeline stage with a valid/ready handshake and a two-entry (output + skid) buffer. The block sits between instruction fetch and decode. It carries {pc, instruction} pairs in order at one pair per cycle. A downstream stall never drops a fetched instruction, and `ready_o` has no combinational path from `ready_i`. A flush squashes everything the stage holds and presents a NOP to decode.

## Interface
Parameters:
- `PC_W`, 32: program-counter width.
- `INST_W`, 32: instruction width.
- `NOP_INST`, 0: value driven on `inst_o` when the stage holds no valid instruction.
- `CNT_W`, 16: performance counter width. Used only with `IF_ID_PERF_EN`.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `flush_i`  in  1  squash all held and incoming instructions.
- `valid_i`  in  1  fetch presents a valid pair.
- `pc_i`  in  PC_W  fetch PC.
- `inst_i`  in  INST_W  fetched instruction.
- `ready_o`  out  1  stage can accept a pair this cycle.
- `valid_o`  out  1  `pc_o`/`inst_o` hold a valid pair.
- `pc_o`  out  PC_W  PC to decode.
- `inst_o`  out  INST_W  instruction to decode.
- `ready_i`  in  1  decode consumes the output; low = hazard stall.
- `stall_cnt_o`  out  CNT_W  (only with `IF_ID_PERF_EN`) stalled-cycle count.
- `flush_cnt_o`  out  CNT_W  (only with `IF_ID_PERF_EN`) squash count.

## Operation
- State: output entry (`valid_o`, `pc_o`, `inst_o`) and skid entry (`skid_v`, `skid_pc`, `skid_inst`).
- `ready_o = !skid_v`. It is a pure function of registered state.
- Accept: `acc = valid_i && ready_o && !flush_i`.
- Consume: `con = valid_o && ready_i`.
- Per-cycle rules, in priority order:
  - `flush_i`: `valid_o`←0, `skid_v`←0, `inst_o`←`NOP_INST`, `pc_o` holds. The input in that cycle is discarded regardless of `valid_i`.
  - Output entry empty or consumed:
    - If `skid_v`: output←skid. Then skid←input if `acc`, else `skid_v`←0.
    - Else if `acc`: output←input.
    - Else: `valid_o`←0, `inst_o`←`NOP_INST`, `pc_o` holds.
  - Output entry full and not consumed: output holds. If `acc`, skid←input.
- Order is strictly preserved: the skid entry is always older than any new input.
- The output registers never change while `valid_o && !ready_i`, except on flush or reset.
- Values on `pc_i`/`inst_i` are ignored when `valid_i` = 0.

## Timing
- Reset values: `valid_o`=0, `skid_v`=0, `ready_o`=1, `pc_o`=0, `inst_o`=`NOP_INST`, skid data=0, counters=0.
- Reset mid-operation immediately clears all valid state; both held pairs are lost.
- Latency: a pair accepted at edge N appears on the outputs after edge N (one cycle) when the stage is empty or draining.
- Throughput is 1 pair per cycle with `ready_i` held high. `ready_o` stays 1 in that steady state.
- On the first stall cycle with `valid_i` high, the skid captures the input. `ready_o` drops the following cycle, so at most one extra pair is absorbed.
- On stall release, the skid drains to the output in the next cycle. `ready_o` returns to 1 in the same cycle.
- Flush while stalled: both entries are cleared at the next edge, `ready_o`=1 after that edge, and `valid_o`=0 for at least one cycle.
- Flush with `ready_i`=1 and `valid_i`=1 in the same cycle: the output is still squashed and the input is not accepted.

## Configuration
- `IF_ID_PERF_EN` defined:
  - Adds `stall_cnt_o`, which increments each cycle with `valid_o && !ready_i`.
  - Adds `flush_cnt_o`, which increments each cycle with `flush_i && (valid_o || skid_v || valid_i)`.
  - Both counters saturate at all-ones and reset to 0.
- `IF_ID_PERF_EN` undefined: both ports and both counters are absent. Datapath behaviour is identical either way.

## Test plan
- Reset: assert `rst_i` mid-clock with both entries full → immediately `valid_o`=0, `ready_o`=1, `pc_o`=0, `inst_o`=`NOP_INST`.
- Streaming: feed pc 0x00,0x04,0x08 with `ready_i`=1 → outputs match one cycle later, `ready_o` constantly 1, no gaps.
- Skid: pc 0x10 in output, drop `ready_i`, offer 0x14 then 0x18 → 0x14 captured, `ready_o`=0, 0x18 held by fetch. Raise `ready_i` → decode receives 0x10, 0x14, 0x18 in order, with no loss or duplication.
- Flush: both entries full (0x20, 0x24) with `ready_i`=0, pulse `flush_i` with `valid_i`=1 pc 0x28 → next cycle `valid_o`=0, `inst_o`=`NOP_INST`, `ready_o`=1, 0x28 never appears.
- Bubble: `valid_i`=0 for two cycles between pc 0x30 and 0x34 → `valid_o` low for two cycles, `inst_o`=`NOP_INST`, `pc_o` holds 0x30.
- Perf (`IF_ID_PERF_EN`, `CNT_W`=4): stall for 20 cycles with `valid_o`=1 → `stall_cnt_o` saturates at 15; three flushes with held data → `flush_cnt_o`=3.
